tape_read_ctrl: RTL and testbench

TAPE_READ_CTRL -- requirements
Module: tape_read_ctrl

---
 rtl/tape_pkg.sv | 29 ++
 rtl/tape_timer.sv | 34 +++
 rtl/tape_read_ctrl.sv | 128 ++++++++++++
 tb/tb_tape_read_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_pkg.sv
// tape_pkg: definitions shared by the paper-tape read controller.
//   tape_state_t  - controller FSM state encoding
//   CHAR_W/ACC_W  - tape character width and assembled-result width
//   CNT_W         - width of the character count on the command interface
//   *_DEF         - default MAX_CHARS and TIMEOUT parameter values
//   clamp_count   - limits a requested character count to the assembler depth
package tape_pkg;

    localparam int CHAR_W        = 5;
    localparam int ACC_W         = 40;
    localparam int CNT_W         = 4;
    localparam int MAX_CHARS_DEF = 8;
    localparam int TIMEOUT_DEF   = 1023;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2,
        ST_DONE     = 2'd3
    } tape_state_t;

    function automatic logic [CNT_W-1:0] clamp_count(
        input logic [CNT_W-1:0] count,
        input logic [CNT_W-1:0] limit
    );
        return (count > limit) ? limit : count;
    endfunction

endpackage

// File: rtl/tape_timer.sv
// tape_timer: cycle counter that bounds each tape handshake phase.
//   clk, resetn - clock and asynchronous active-low reset
//   clear       - zero the count (has priority over enable)
//   enable      - count this cycle
//   expired     - this is the TIMEOUT-th enabled cycle since the last clear
module tape_timer #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TW'(1);
        end
    end

    // Flagged during the last allowed cycle so the owner leaves the phase on
    // the edge that completes exactly TIMEOUT cycles of waiting.
    assign expired = enable && (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/tape_read_ctrl.sv
// tape_read_ctrl: reads up to MAX_CHARS 5-bit characters from a tape reader
// per command and returns them packed, most recent character in bits [4:0].
//   clk, resetn          - clock, asynchronous active-low reset
//   cmd_val/cmd_rdy      - command handshake, cmd_count = characters wanted
//   rsp_val/rsp_rdy      - result handshake, rsp_data/rsp_err held in DONE
//   input_rdy/input_val  - per-character handshake with the tape reader
//   input_data           - tape character
//   state_dbg            - current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising edge where both val and rdy are
// high. cmd_rdy is high only in IDLE, rsp_val only in DONE, input_rdy only in
// REQ. The reader side is four-phase: after a character is captured the
// controller waits for input_val to fall before asking for the next one.
module tape_read_ctrl
    import tape_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int MAX_CHARS = MAX_CHARS_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_val,
    output logic              cmd_rdy,
    input  logic [CNT_W-1:0]  cmd_count,
    output logic              rsp_val,
    input  logic              rsp_rdy,
    output logic [ACC_W-1:0]  rsp_data,
    output logic              rsp_err,
    output logic              input_rdy,
    input  logic              input_val,
    input  logic [CHAR_W-1:0] input_data,
    output tape_state_t       state_dbg
);

    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(MAX_CHARS);

    tape_state_t       state, state_next;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [CNT_W-1:0]  remaining, remaining_next;
    logic              err, err_next;
    logic [CNT_W-1:0]  start_count;
    logic              timer_clear, timer_en, timer_expired;

    assign start_count = clamp_count(cmd_count, MAX_LIM);

    tape_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            acc       <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            remaining <= remaining_next;
            err       <= err_next;
        end
    end

    always_comb begin
        state_next     = state;
        acc_next       = acc;
        remaining_next = remaining;
        err_next       = err;

        case (state)
            ST_IDLE: begin
                if (cmd_val) begin
                    acc_next       = '0;
                    err_next       = 1'b0;
                    remaining_next = start_count;
                    state_next     = (start_count == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                // A capture on the timeout edge still counts as a good read.
                if (input_val) begin
                    acc_next       = {acc[ACC_W-CHAR_W-1:0], input_data};
                    remaining_next = remaining - CNT_W'(1);
                    state_next     = ST_WAIT_LOW;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_WAIT_LOW: begin
                // The reader releasing input_val completes the phase even on
                // the timeout edge; only a reader still holding it is an error.
                if (!input_val) begin
                    state_next = (remaining != '0) ? ST_REQ : ST_DONE;
                end else if (timer_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_rdy) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on every phase change, so each wait is bounded separately.
    assign timer_en    = (state == ST_REQ) || (state == ST_WAIT_LOW);
    assign timer_clear = (state_next != state);

    assign cmd_rdy   = (state == ST_IDLE);
    assign rsp_val   = (state == ST_DONE);
    assign input_rdy = (state == ST_REQ);
    assign rsp_data  = acc;
    assign rsp_err   = err;
    assign state_dbg = state;

endmodule

// File: tb/tb_tape_read_ctrl.sv
// tb_tape_read_ctrl: directed and randomized checks of tape_read_ctrl against
// a transaction-level model of what each command must return and how many
// cycles it must spend asking for and releasing characters.
module tb_tape_read_ctrl;
    import tape_pkg::*;

    localparam int T    = 16;
    localparam int MAXC = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic              cmd_val = 1'b0;
    logic              cmd_rdy;
    logic [CNT_W-1:0]  cmd_count = '0;
    logic              rsp_val;
    logic              rsp_rdy = 1'b0;
    logic [ACC_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              input_rdy;
    logic              input_val = 1'b0;
    logic [CHAR_W-1:0] input_data = '0;
    tape_state_t       state_dbg;

    tape_read_ctrl #(
        .TIMEOUT   (T),
        .MAX_CHARS (MAXC)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_val    (cmd_val),
        .cmd_rdy    (cmd_rdy),
        .cmd_count  (cmd_count),
        .rsp_val    (rsp_val),
        .rsp_rdy    (rsp_rdy),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .input_rdy  (input_rdy),
        .input_val  (input_val),
        .input_data (input_data),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [39:0] data;
        logic        err;
        logic [7:0]  pulses;    // input_rdy rising edges in the command
        logic [15:0] rdy_cyc;   // cycles with input_rdy high
        logic [15:0] wait_cyc;  // cycles waiting for the reader to release
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reader plan per character: cycles of input_rdy before answering, and
    // extra cycles input_val stays high after capture.
    int          plan_d[MAXC];
    int          plan_h[MAXC];
    logic [4:0]  plan_c[MAXC];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Command outcome from the rules: each character costs min(d+1,T) cycles
    // asking and min(h+1,T) cycles releasing; hitting T in either ends it.
    function automatic exp_t model(input int count);
        exp_t e;
        int   n;
        e = '0;
        n = (count > MAXC) ? MAXC : count;
        for (int i = 0; i < n; i++) begin
            e.pulses = e.pulses + 8'd1;
            if (plan_d[i] >= T) begin
                e.rdy_cyc = e.rdy_cyc + 16'(T);
                e.err = 1'b1;
                break;
            end
            e.rdy_cyc = e.rdy_cyc + 16'(plan_d[i] + 1);
            e.data = {e.data[34:0], plan_c[i]};
            if (plan_h[i] >= T) begin
                e.wait_cyc = e.wait_cyc + 16'(T);
                e.err = 1'b1;
                break;
            end
            e.wait_cyc = e.wait_cyc + 16'(plan_h[i] + 1);
        end
        return e;
    endfunction

    // ---------------- compare process ----------------
    logic in_flight = 1'b0;
    int   pulses = 0, rdy_cyc = 0, wait_cyc = 0;
    logic prev_rdy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                in_flight = 1'b0;
                pulses = 0; rdy_cyc = 0; wait_cyc = 0;
                prev_rdy = 1'b0;
            end else begin
                check("cmd_rdy", 96'(cmd_rdy), 96'(!in_flight));
                check("rdy_val_excl", 96'(input_rdy && rsp_val), 96'(0));
                if (input_rdy && !prev_rdy) pulses++;
                if (input_rdy) rdy_cyc++;
                if (!cmd_rdy && !input_rdy && !rsp_val) wait_cyc++;
                prev_rdy = input_rdy;
                if (rsp_val) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got rsp_val=1 data=%0h, expected no response", rsp_data);
                    end else begin
                        check("rsp_data", 96'(rsp_data), 96'(exp_q[0].data));
                        check("rsp_err", 96'(rsp_err), 96'(exp_q[0].err));
                        if (rsp_rdy) begin
                            check("rdy_pulses", 96'(pulses), 96'(exp_q[0].pulses));
                            check("rdy_cycles", 96'(rdy_cyc), 96'(exp_q[0].rdy_cyc));
                            check("wait_cycles", 96'(wait_cyc), 96'(exp_q[0].wait_cyc));
                            void'(exp_q.pop_front());
                            pulses = 0; rdy_cyc = 0; wait_cyc = 0;
                        end
                    end
                end
                if (cmd_val && cmd_rdy) in_flight = 1'b1;
                if (rsp_val && rsp_rdy) in_flight = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reader();
        int i = 0;
        int cnt = 0;
        bit hold = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (rsp_val || !resetn) begin
                input_val = 1'b0;
                return;
            end
            if (!hold) begin
                if (input_rdy && i < MAXC) begin
                    if (cnt >= plan_d[i]) begin
                        input_val = 1'b1;
                        input_data = plan_c[i];
                        hold = 1'b1;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                if (cnt >= plan_h[i]) begin
                    input_val = 1'b0;
                    hold = 1'b0;
                    cnt = 0;
                    i++;
                end else begin
                    cnt++;
                end
            end
            tick();
        end
        input_val = 1'b0;
    endtask

    task automatic responder(input int stall, input bit poke);
        int k = 0;
        while (!rsp_val && k < 3000) begin
            tick();
            k++;
        end
        if (!rsp_val) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_val in %0d cycles, expected a response", k);
            return;
        end
        // Commands offered while busy must be dropped, not queued.
        if (poke) begin
            cmd_val = 1'b1;
            cmd_count = 4'd3;
        end
        for (int s = 0; s < stall; s++) tick();
        cmd_val = 1'b0;
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;
    endtask

    task automatic run_cmd(input int count, input exp_t e, input int stall, input bit poke);
        exp_q.push_back(e);
        cmd_val = 1'b1;
        cmd_count = CNT_W'(count);
        tick();
        cmd_val = 1'b0;
        fork
            reader();
            responder(stall, poke);
        join
    endtask

    task automatic plan_fill(input int d, input int h);
        for (int i = 0; i < MAXC; i++) begin
            plan_d[i] = d;
            plan_h[i] = h;
            plan_c[i] = 5'(i + 1);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        plan_fill(0, 0);
        #12;
        check("reset_cmd_rdy", 96'(cmd_rdy), 96'(1));
        check("reset_outs", 96'({input_rdy, rsp_val, rsp_err}), 96'(0));
        check("reset_data", 96'(rsp_data), 96'(0));
        tick();
        resetn = 1'b1;
        tick();

        // Two characters 13, 0A.
        plan_fill(0, 0);
        plan_c[0] = 5'h13;
        plan_c[1] = 5'h0A;
        check("model_pin_26a", 96'(model(2)), 96'(exp_t'{40'h26A, 1'b0, 8'd2, 16'd2, 16'd2}));
        run_cmd(2, exp_t'{40'h26A, 1'b0, 8'd2, 16'd2, 16'd2}, 0, 1'b0);

        // Reader never answers: 16 cycles of input_rdy then error.
        plan_fill(100, 0);
        run_cmd(3, exp_t'{40'h0, 1'b1, 8'd1, 16'd16, 16'd0}, 1, 1'b0);

        // Zero-length command goes straight to the response.
        plan_fill(0, 0);
        run_cmd(0, exp_t'{40'h0, 1'b0, 8'd0, 16'd0, 16'd0}, 0, 1'b0);

        // Request of 12 is limited to 8 characters.
        plan_fill(0, 0);
        check("model_pin_max", 96'(model(12)), 96'(exp_t'{40'h08_8642_98E8, 1'b0, 8'd8, 16'd8, 16'd8}));
        run_cmd(12, exp_t'{40'h08_8642_98E8, 1'b0, 8'd8, 16'd8, 16'd8}, 0, 1'b0);

        // Response held 5 cycles while a new command is offered.
        plan_fill(1, 2);
        run_cmd(2, model(2), 5, 1'b1);

        // Answer on the very last cycle before timeout still counts.
        plan_fill(0, 0);
        plan_d[0] = T - 1;
        plan_c[0] = 5'h1F;
        run_cmd(1, exp_t'{40'h1F, 1'b0, 8'd1, 16'd16, 16'd1}, 0, 1'b0);

        // Reader never releases: timeout while waiting for input_val low.
        plan_fill(0, 0);
        plan_h[0] = 20;
        plan_c[0] = 5'h11;
        run_cmd(2, exp_t'{40'h11, 1'b1, 8'd1, 16'd1, 16'd16}, 0, 1'b0);

        // Reset while waiting for the reader to release.
        cmd_val = 1'b1;
        cmd_count = 4'd3;
        tick();
        cmd_val = 1'b0;
        input_val = 1'b1;
        input_data = 5'h05;
        tick();
        input_data = 5'h00;
        tick();
        check("pre_reset_wait_low", 96'({input_rdy, rsp_val, cmd_rdy}), 96'(0));
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_ctrl", 96'({input_rdy, rsp_val}), 96'(0));
        check("async_reset_cmd_rdy", 96'(cmd_rdy), 96'(1));
        check("async_reset_result", 96'({rsp_data, rsp_err}), 96'(0));
        input_val = 1'b0;
        exp_q.delete();
        tick();
        tick();
        resetn = 1'b1;
        repeat (6) tick();
        check("post_reset_no_rsp", 96'({rsp_val, cmd_rdy}), 96'(1));

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            int r;
            int cnt;
            for (int i = 0; i < MAXC; i++) begin
                plan_c[i] = 5'($urandom_range(0, 31));
                r = $urandom_range(0, 9);
                plan_d[i] = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? T - 1 : (r == 8) ? T : T + 2;
                r = $urandom_range(0, 9);
                plan_h[i] = (r < 8) ? $urandom_range(0, 3) : (r == 8) ? T : T + 1;
            end
            cnt = $urandom_range(0, 15);
            run_cmd(cnt, model(cnt), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        check("end_queue_empty", 96'(exp_q.size()), 96'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
